// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD conversion / 7-segment scan controller.
// Segment patterns are active-low in {g,f,e,d,c,b,a} order.
package bcd_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    localparam int NUM_DIGITS = 3;
    localparam int BIN_W      = 8;
    localparam int BCD_W      = 4 * NUM_DIGITS;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;

    // Double-dabble column correction applied before every shift.
    function automatic logic [3:0] add3_adjust(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-low 7-segment decoder.
// Blanked digits and non-decimal codes both produce an all-off pattern.
module seg7_decode
    import bcd_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            case (digit_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/bcd_seg_scan_ctrl.sv
// Sequential 8-bit binary to 3-digit BCD converter (one shift per clock) that
// latches its result and time-multiplexes it onto a common-anode 7-segment display.
module bcd_seg_scan_ctrl
    import bcd_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter bit LZ_BLANK    = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [BIN_W-1:0] bin_in,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [3:0]       hundreds,
    output logic [3:0]       tens,
    output logic [3:0]       ones,
    output logic [2:0]       an,
    output logic [6:0]       seg,
    output state_e           dbg_state
);

    localparam int                 PRESC_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);

    // Handshake: start is level-sampled only while idle; busy is high for the
    // eight shift cycles and done pulses for one cycle as the digits are latched.

    state_e             state_q;
    logic [BIN_W-1:0]   shift_q;
    logic [BCD_W-1:0]   scratch_q;
    logic [2:0]         count_q;
    logic               busy_q;
    logic               done_q;
    logic [3:0]         hundreds_q;
    logic [3:0]         tens_q;
    logic [3:0]         ones_q;

    logic [BCD_W-1:0]   adj_d;
    logic [BCD_W-1:0]   scratch_d;
    logic [BIN_W-1:0]   shift_d;

    always_comb begin
        adj_d = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            adj_d[4*i +: 4] = add3_adjust(scratch_q[4*i +: 4]);
        end
    end

    assign {scratch_d, shift_d} = {adj_d, shift_q} << 1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            scratch_q  <= '0;
            count_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            hundreds_q <= '0;
            tens_q     <= '0;
            ones_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        shift_q   <= bin_in;
                        scratch_q <= '0;
                        count_q   <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    shift_q   <= shift_d;
                    scratch_q <= scratch_d;
                    count_q   <= count_q + 3'd1;
                    // Eighth shift: publish the post-shift scratch directly.
                    if (count_q == 3'd7) begin
                        hundreds_q <= scratch_d[11:8];
                        tens_q     <= scratch_d[7:4];
                        ones_q     <= scratch_d[3:0];
                        done_q     <= 1'b1;
                        busy_q     <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    logic [PRESC_W-1:0] presc_q;
    logic [1:0]         idx_q;
    logic [2:0]         an_q;
    logic [6:0]         seg_q;

    logic [3:0]         digit_mux;
    logic               blank_mux;
    logic [2:0]         an_d;
    logic [6:0]         seg_d;

    always_comb begin
        digit_mux = ones_q;
        blank_mux = 1'b0;
        an_d      = 3'b110;
        case (idx_q)
            2'd1: begin
                digit_mux = tens_q;
                blank_mux = LZ_BLANK && (hundreds_q == 4'd0) && (tens_q == 4'd0);
                an_d      = 3'b101;
            end
            2'd2: begin
                digit_mux = hundreds_q;
                blank_mux = LZ_BLANK && (hundreds_q == 4'd0);
                an_d      = 3'b011;
            end
            default: ;
        endcase
    end

    seg7_decode u_dec (
        .digit_i (digit_mux),
        .blank_i (blank_mux),
        .seg_o   (seg_d)
    );

    // Scan runs free of the converter; an/seg are registered so pins never glitch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc_q <= '0;
            idx_q   <= '0;
            an_q    <= 3'b110;
            seg_q   <= SEG_0;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            if (presc_q == PRESC_LAST) begin
                presc_q <= '0;
                idx_q   <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
            end else begin
                presc_q <= presc_q + 1'b1;
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign hundreds  = hundreds_q;
    assign tens      = tens_q;
    assign ones      = ones_q;
    assign an        = an_q;
    assign seg       = seg_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_bcd_seg_scan_ctrl.sv
// Self-checking bench for bcd_seg_scan_ctrl: vector table, exhaustive sweep,
// busy/ignore and reset corner cases, and display scan/blanking on two instances.
module tb_bcd_seg_scan_ctrl;
    import bcd_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] bin_in;
    logic       start;

    logic       busy1, done1, busy0, done0;
    logic [3:0] h1, t1, o1, h0, t0, o0;
    logic [2:0] an1, an0;
    logic [6:0] seg1, seg0;
    state_e     st1, st0;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] exp_q[$];
    logic [6:0] seg_tab[10];

    typedef struct {
        logic [7:0] v;
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] o;
    } vec_t;
    vec_t tab[16];

    always #5 clk = ~clk;

    bcd_seg_scan_ctrl #(.REFRESH_DIV(4), .LZ_BLANK(1'b1)) u_lz1 (
        .clk(clk), .reset(reset), .bin_in(bin_in), .start(start),
        .busy(busy1), .done(done1), .hundreds(h1), .tens(t1), .ones(o1),
        .an(an1), .seg(seg1), .dbg_state(st1)
    );

    bcd_seg_scan_ctrl #(.REFRESH_DIV(4), .LZ_BLANK(1'b0)) u_lz0 (
        .clk(clk), .reset(reset), .bin_in(bin_in), .start(start),
        .busy(busy0), .done(done0), .hundreds(h0), .tens(t0), .ones(o0),
        .an(an0), .seg(seg0), .dbg_state(st0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_digits(input string name, input int v);
        check({name, "_h"}, {28'd0, h1}, v / 100);
        check({name, "_t"}, {28'd0, t1}, (v / 10) % 10);
        check({name, "_o"}, {28'd0, o1}, v % 10);
    endtask

    // Display a digit position should show, from the decimal value alone.
    function automatic logic [6:0] exp_seg(input logic [2:0] a, input int val, input bit lz);
        int  h, t, o, d;
        bit  blank;
        h = val / 100;
        t = (val / 10) % 10;
        o = val % 10;
        d = o;
        blank = 1'b0;
        case (a)
            3'b110: d = o;
            3'b101: begin d = t; blank = lz && (h == 0) && (t == 0); end
            3'b011: begin d = h; blank = lz && (h == 0); end
            default: return 7'h00;
        endcase
        return blank ? 7'h7F : seg_tab[d];
    endfunction

    function automatic logic [2:0] next_an(input logic [2:0] a);
        case (a)
            3'b110:  return 3'b101;
            3'b101:  return 3'b011;
            default: return 3'b110;
        endcase
    endfunction

    // Pulse start with value v; lat = edges after the accepting edge until done is seen.
    task automatic run_conv(input logic [7:0] v, output int lat);
        @(negedge clk);
        bin_in = v;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        while (!done1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic scan_check(input int v, input string name);
        logic [2:0] prev;
        int         run;
        int         changes;
        bit         seen;
        @(negedge clk);
        prev    = an1;
        run     = 0;
        changes = 0;
        seen    = 1'b0;
        for (int c = 0; c < 28; c++) begin
            @(negedge clk);
            check({name, "_an_valid"}, (an1 == 3'b110 || an1 == 3'b101 || an1 == 3'b011), 1);
            check({name, "_seg_lz1"}, {25'd0, seg1}, {25'd0, exp_seg(an1, v, 1'b1)});
            check({name, "_seg_lz0"}, {25'd0, seg0}, {25'd0, exp_seg(an0, v, 1'b0)});
            if (an1 != prev) begin
                if (seen) check({name, "_dwell"}, run, 4);
                check({name, "_order"}, {29'd0, an1}, {29'd0, next_an(prev)});
                seen = 1'b1;
                changes++;
                run  = 1;
                prev = an1;
            end else begin
                run++;
            end
        end
        check({name, "_advances"}, changes >= 6, 1);
    endtask

    initial begin
        int lat, ndone, nxt, cyc, last;
        logic [7:0] v;

        seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001;
        seg_tab[2] = 7'b0100100; seg_tab[3] = 7'b0110000;
        seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
        seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000;
        seg_tab[8] = 7'b0000000; seg_tab[9] = 7'b0010000;

        begin
            logic [7:0] fixed[10];
            fixed = '{8'd0, 8'd9, 8'd10, 8'd99, 8'd100, 8'd105, 8'd199, 8'd200, 8'd255, 8'd127};
            for (int i = 0; i < 16; i++) begin
                tab[i].v = (i < 10) ? fixed[i] : 8'($urandom_range(0, 255));
                tab[i].h = 4'(tab[i].v / 100);
                tab[i].t = 4'((tab[i].v / 10) % 10);
                tab[i].o = 4'(tab[i].v % 10);
            end
        end

        // Reset state
        reset  = 1'b1;
        start  = 1'b0;
        bin_in = 8'd0;
        repeat (3) begin
            @(negedge clk);
            check("rst_busy", busy1, 0);
            check("rst_done", done1, 0);
            check("rst_an", {29'd0, an1}, 3'b110);
            check("rst_seg", {25'd0, seg1}, 7'b1000000);
            check_digits("rst", 0);
        end
        reset = 1'b0;

        // Single conversion of 255 with cycle-accurate busy/done
        @(negedge clk);
        bin_in = 8'd255;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == 2) bin_in = 8'd0;
            check("c255_busy", busy1, 1);
            check("c255_done_low", done1, 0);
            check("c255_state", st1 == ST_SHIFT, 1);
            @(negedge clk);
        end
        check("c255_busy_end", busy1, 0);
        check("c255_done", done1, 1);
        check_digits("c255", 255);
        @(negedge clk);
        check("c255_done_pulse", done1, 0);
        check_digits("c255_hold", 255);

        // Vector table
        for (int i = 0; i < 16; i++) begin
            run_conv(tab[i].v, lat);
            check("tab_latency", lat, 8);
            check("tab_h", {28'd0, h1}, {28'd0, tab[i].h});
            check("tab_t", {28'd0, t1}, {28'd0, tab[i].t});
            check("tab_o", {28'd0, o1}, {28'd0, tab[i].o});
        end

        // Exhaustive sweep with start held high
        exp_q.delete();
        @(negedge clk);
        bin_in = 8'd0;
        start  = 1'b1;
        exp_q.push_back(8'd0);
        nxt   = 1;
        ndone = 0;
        cyc   = 0;
        last  = 0;
        while (ndone < 256 && cyc < 256 * 9 + 40) begin
            @(negedge clk);
            cyc++;
            if (done1) begin
                if (exp_q.size() > 0) begin
                    v = exp_q.pop_front();
                    check_digits("exh", int'(v));
                end else begin
                    check("exh_unexpected_done", 1, 0);
                end
                if (ndone > 0) check("exh_period", cyc - last, 9);
                last = cyc;
                ndone++;
                if (nxt < 256) begin
                    bin_in = 8'(nxt);
                    exp_q.push_back(8'(nxt));
                    nxt++;
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        check("exh_count", ndone, 256);

        // Start ignored while busy
        @(negedge clk);
        @(negedge clk);
        bin_in = 8'd127;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bin_in = 8'd42;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done1) begin
                ndone++;
                check_digits("ign", 127);
            end
        end
        check("ign_done_count", ndone, 1);
        check_digits("ign_hold", 127);
        run_conv(8'd42, lat);
        check("ign_next_latency", lat, 8);
        check_digits("ign_next", 42);

        // Scan and blanking
        run_conv(8'd7, lat);
        scan_check(7, "scan7");
        run_conv(8'd105, lat);
        scan_check(105, "scan105");
        run_conv(8'd0, lat);
        scan_check(0, "scan0");
        run_conv(8'd250, lat);
        scan_check(250, "scan250");

        // Reset in the middle of a conversion
        run_conv(8'd200, lat);
        check_digits("pre_rst", 200);
        @(negedge clk);
        bin_in = 8'd99;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #1 reset = 1'b1;
        ndone = 0;
        repeat (3) begin
            @(negedge clk);
            check("mrst_busy", busy1, 0);
            check("mrst_an", {29'd0, an1}, 3'b110);
            check("mrst_seg", {25'd0, seg1}, 7'b1000000);
            check_digits("mrst", 0);
            if (done1) ndone++;
        end
        reset = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (done1) ndone++;
        end
        check("mrst_no_done", ndone, 0);
        check_digits("mrst_after", 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
